// File: rtl/pll_ce_gen.sv
// Enable-based stand-in for a vendor PLL: CHANNELS divided clocks and one-cycle
// clock enables on inclk0, with run-time divisor reprogramming and a modelled lock time.
module pll_ce_gen #(
    parameter int CHANNELS    = 2,
    parameter int DIV_W       = 8,
    parameter int DIV_INIT    = 1,
    parameter int LOCK_CYCLES = 16
) (
    input  logic                inclk0,
    input  logic                reset_n,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [2:0]          cfg_chan,
    input  logic [DIV_W-1:0]    cfg_div,
    output logic [CHANNELS-1:0] c,
    output logic [CHANNELS-1:0] ce,
    output logic                locked
);

    localparam int                LCNT_W    = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [LCNT_W-1:0] LOCK_LAST = LCNT_W'(LOCK_CYCLES - 1);
    localparam logic [3:0]        CHAN_LIM  = 4'(CHANNELS);
    localparam logic [DIV_W-1:0]  DIV_RST   = DIV_W'(DIV_INIT);

    typedef enum logic {
        LOCKING = 1'b0,
        LOCKED  = 1'b1
    } state_t;

    state_t                           state_q, state_d;
    logic [LCNT_W-1:0]                lock_cnt_q, lock_cnt_d;
    logic [CHANNELS-1:0][DIV_W-1:0]   div_q, div_d;
    logic [CHANNELS-1:0][DIV_W-1:0]   cnt_q, cnt_d;
    logic [CHANNELS-1:0]              c_q, c_d;
    logic [CHANNELS-1:0]              ce_q, ce_d;
    logic                             locked_q, locked_d;
    logic                             accept;
    logic                             chan_hit;

    // A zero divisor has no meaningful period, so it is treated as a divide-by-one.
    function automatic logic [DIV_W-1:0] sanitize_div(input logic [DIV_W-1:0] dv);
        return (dv == '0) ? DIV_W'(1) : dv;
    endfunction

    // Length of the high phase; rounding up makes odd divisors one cycle longer high.
    function automatic logic [DIV_W:0] high_len(input logic [DIV_W-1:0] dv);
        logic [DIV_W:0] ext;
        ext = {1'b0, dv} + (DIV_W+1)'(1);
        return ext >> 1;
    endfunction

    assign accept   = cfg_valid & locked_q;
    assign chan_hit = accept && ({1'b0, cfg_chan} < CHAN_LIM);

    always_comb begin
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
        div_d      = div_q;
        case (state_q)
            LOCKING: begin
                if (lock_cnt_q == LOCK_LAST) begin
                    state_d    = LOCKED;
                    lock_cnt_d = '0;
                end else begin
                    lock_cnt_d = lock_cnt_q + LCNT_W'(1);
                end
            end
            LOCKED: begin
                if (chan_hit) begin
                    state_d    = LOCKING;
                    lock_cnt_d = '0;
                    for (int i = 0; i < CHANNELS; i++) begin
                        if (cfg_chan == 3'(i)) begin
                            div_d[i] = sanitize_div(cfg_div);
                        end
                    end
                end
            end
            default: begin
                state_d    = LOCKING;
                lock_cnt_d = '0;
            end
        endcase
    end

    // Outputs are computed from next-cycle counter values so the registered
    // c/ce line up with the counter value of the cycle in which they appear.
    always_comb begin
        cnt_d    = '0;
        c_d      = '0;
        ce_d     = '0;
        locked_d = (state_d == LOCKED);
        for (int i = 0; i < CHANNELS; i++) begin
            if ((state_q == LOCKED) && (state_d == LOCKED)) begin
                if (cnt_q[i] == div_q[i] - DIV_W'(1)) begin
                    cnt_d[i] = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + DIV_W'(1);
                end
            end
            if (state_d == LOCKED) begin
                ce_d[i] = (cnt_d[i] == div_d[i] - DIV_W'(1));
                c_d[i]  = ({1'b0, cnt_d[i]} < high_len(div_d[i]));
            end
        end
    end

    always_ff @(posedge inclk0 or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= LOCKING;
            lock_cnt_q <= '0;
            div_q      <= {CHANNELS{DIV_RST}};
            cnt_q      <= '0;
            c_q        <= '0;
            ce_q       <= '0;
            locked_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            lock_cnt_q <= lock_cnt_d;
            div_q      <= div_d;
            cnt_q      <= cnt_d;
            c_q        <= c_d;
            ce_q       <= ce_d;
            locked_q   <= locked_d;
        end
    end

    assign c         = c_q;
    assign ce        = ce_q;
    assign locked    = locked_q;
    assign cfg_ready = locked_q;

endmodule

// File: tb/tb_pll_ce_gen.sv
// Directed bench for pll_ce_gen: a cycle model pushes expected outputs to a
// scoreboard at each rising edge; they are popped and compared at the falling edge.
module tb_pll_ce_gen;

    localparam int CH = 2;
    localparam int DW = 8;
    localparam int LC = 16;

    logic          inclk0    = 1'b0;
    logic          reset_n   = 1'b1;
    logic          cfg_valid = 1'b0;
    logic [2:0]    cfg_chan  = '0;
    logic [DW-1:0] cfg_div   = '0;
    logic          cfg_ready;
    logic          locked;
    logic [CH-1:0] c;
    logic [CH-1:0] ce;

    always #5 inclk0 = ~inclk0;

    pll_ce_gen #(
        .CHANNELS   (CH),
        .DIV_W      (DW),
        .DIV_INIT   (1),
        .LOCK_CYCLES(LC)
    ) dut (
        .inclk0   (inclk0),
        .reset_n  (reset_n),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_chan (cfg_chan),
        .cfg_div  (cfg_div),
        .c        (c),
        .ce       (ce),
        .locked   (locked)
    );

    typedef struct packed {
        logic          lck;
        logic          rdy;
        logic [CH-1:0] cv;
        logic [CH-1:0] cev;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    bit m_locked;
    int m_lockcnt;
    int m_phase;
    int m_div[CH];

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_locked  = 1'b0;
        m_lockcnt = 0;
        m_phase   = 0;
        for (int i = 0; i < CH; i++) m_div[i] = 1;
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e     = '0;
        e.lck = m_locked;
        e.rdy = m_locked;
        if (m_locked) begin
            for (int i = 0; i < CH; i++) begin
                e.cev[i] = (((m_phase + 1) % m_div[i]) == 0);
                e.cv[i]  = ((m_phase % m_div[i]) < ((m_div[i] + 1) / 2));
            end
        end
        return e;
    endfunction

    task automatic tick();
        exp_t e;
        int   ci;
        @(posedge inclk0);
        ci = int'(cfg_chan);
        if (!reset_n) begin
            model_reset();
        end else if (!m_locked) begin
            m_lockcnt++;
            if (m_lockcnt == LC) begin
                m_locked = 1'b1;
                m_phase  = 0;
            end
        end else if (cfg_valid && (ci < CH)) begin
            m_div[ci] = (cfg_div == '0) ? 1 : int'(cfg_div);
            m_locked  = 1'b0;
            m_lockcnt = 0;
        end else begin
            m_phase++;
        end
        sb.push_back(model_out());
        @(negedge inclk0);
        e = sb.pop_front();
        check("locked", 8'(locked), 8'(e.lck));
        check("cfg_ready", 8'(cfg_ready), 8'(e.rdy));
        check("c", 8'(c), 8'(e.cv));
        check("ce", 8'(ce), 8'(e.cev));
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    // Holds cfg_valid until the DUT shows cfg_ready, then completes the accepting edge.
    task automatic send(input logic [2:0] ch, input logic [DW-1:0] dv, input int budget);
        bit done;
        done      = 1'b0;
        cfg_chan  = ch;
        cfg_div   = dv;
        cfg_valid = 1'b1;
        for (int k = 0; k < budget && !done; k++) begin
            if (cfg_ready === 1'b1) done = 1'b1;
            tick();
        end
        cfg_valid = 1'b0;
        check("send_accept", 8'(done), 8'd1);
    endtask

    initial begin
        logic [11:0] t_c0, t_ce0, t_c1, t_ce1;
        int          gap;
        t_c0  = 12'b110011001100;
        t_ce0 = 12'b000100010001;
        t_c1  = 12'b110110110110;
        t_ce1 = 12'b001001001001;
        model_reset();

        #1 reset_n = 1'b0;
        #2;
        check("rst_locked", 8'(locked), 8'd0);
        check("rst_ready", 8'(cfg_ready), 8'd0);
        check("rst_c", 8'(c), 8'd0);
        check("rst_ce", 8'(ce), 8'd0);
        ticks(2);
        reset_n = 1'b1;

        ticks(LC + 4);
        check("pwr_ce_all", 8'(ce), 8'h03);

        send(3'd0, 8'd4, 40);
        send(3'd1, 8'd3, 40);
        gap = 1;
        while ((locked !== 1'b1) && (gap < 40)) begin
            tick();
            if (locked !== 1'b1) gap++;
        end
        check("lock_gap", 8'(gap), 8'(LC));
        for (int k = 0; k < 12; k++) begin
            if (k > 0) tick();
            check("pat_c", 8'(c), 8'({t_c1[11-k], t_c0[11-k]}));
            check("pat_ce", 8'(ce), 8'({t_ce1[11-k], t_ce0[11-k]}));
        end

        send(3'd0, 8'd0, 40);
        ticks(LC + 6);
        check("div0_ce0", 8'(ce[0]), 8'd1);
        send(3'd5, 8'd7, 40);
        check("chan5_locked", 8'(locked), 8'd1);
        ticks(8);

        send(3'd0, 8'd4, 40);
        ticks(LC + 5);
        reset_n = 1'b0;
        #1;
        check("async_locked", 8'(locked), 8'd0);
        check("async_c", 8'(c), 8'd0);
        check("async_ce", 8'(ce), 8'd0);
        ticks(2);
        reset_n = 1'b1;
        ticks(LC + 4);
        check("relock_ce_all", 8'(ce), 8'h03);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
